// File: rtl/hermes_periph_bridge.sv
// rtl/hermes_periph_bridge.sv - Hermes edge port <-> peripheral stream bridge
// RX: FIFO-buffered packet parser to a framed stream; TX: request-driven packet builder.
module hermes_periph_bridge #(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8,
   parameter int CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 release_i,
   input  logic                 noc_rx_i,
   output logic                 noc_credit_o,
   input  logic [FLIT_SIZE-1:0] noc_data_i,
   output logic                 noc_tx_o,
   input  logic                 noc_credit_i,
   output logic [FLIT_SIZE-1:0] noc_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic [FLIT_SIZE-1:0] rx_data_o,
   output logic                 rx_sop_o,
   output logic                 rx_eop_o,
   input  logic                 tx_req_i,
   input  logic [15:0]          tx_target_i,
   input  logic [FLIT_SIZE-1:0] tx_size_i,
   output logic                 tx_busy_o,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   input  logic [FLIT_SIZE-1:0] tx_data_i,
   output logic [CNT_W-1:0]     rx_pkt_cnt_o,
   output logic [CNT_W-1:0]     tx_pkt_cnt_o
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);

   typedef enum logic [1:0] {RX_HDR, RX_SIZE, RX_PAYLOAD} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_SIZE, TX_PAYLOAD} tx_state_e;

   logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
   logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;
   logic                 w_empty, w_full, w_push, w_pop;
   logic [FLIT_SIZE-1:0] w_head;

   rx_state_e            r_rx_state, w_rx_next;
   logic [FLIT_SIZE-1:0] r_rx_rem;
   logic                 r_rx_first, w_rx_done;

   tx_state_e            r_tx_state, w_tx_next;
   logic [15:0]          r_tx_target;
   logic [FLIT_SIZE-1:0] r_tx_size, r_tx_rem;
   logic                 w_tx_done, w_tx_xfer;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

   assign noc_credit_o = release_i && !w_full;
   assign w_push       = noc_rx_i && noc_credit_o;

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= noc_data_i;
   end

   always_comb begin
      w_rx_next  = r_rx_state;
      w_pop      = 1'b0;
      w_rx_done  = 1'b0;
      rx_valid_o = 1'b0;
      case (r_rx_state)
         RX_HDR: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_rx_next = RX_SIZE;
            end
         end
         RX_SIZE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head == '0) begin
                  w_rx_done = 1'b1;
                  w_rx_next = RX_HDR;
               end else begin
                  w_rx_next = RX_PAYLOAD;
               end
            end
         end
         RX_PAYLOAD: begin
            rx_valid_o = !w_empty;
            if (rx_valid_o && rx_ready_i) begin
               w_pop = 1'b1;
               if (r_rx_rem == FLIT_SIZE'(1)) begin
                  w_rx_done = 1'b1;
                  w_rx_next = RX_HDR;
               end
            end
         end
         default: w_rx_next = RX_HDR;
      endcase
   end

   assign rx_data_o = rx_valid_o ? w_head : '0;
   assign rx_sop_o  = rx_valid_o && r_rx_first;
   assign rx_eop_o  = rx_valid_o && (r_rx_rem == FLIT_SIZE'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_rx_state   <= RX_HDR;
         r_rx_rem     <= '0;
         r_rx_first   <= 1'b0;
         rx_pkt_cnt_o <= '0;
      end else begin
         r_rx_state <= w_rx_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_pop && r_rx_state == RX_SIZE) begin
            r_rx_rem   <= w_head;
            r_rx_first <= 1'b1;
         end else if (w_pop && r_rx_state == RX_PAYLOAD) begin
            r_rx_rem   <= r_rx_rem - FLIT_SIZE'(1);
            r_rx_first <= 1'b0;
         end
         if (w_rx_done) rx_pkt_cnt_o <= rx_pkt_cnt_o + CNT_W'(1);
      end
   end

   always_comb begin
      w_tx_next  = r_tx_state;
      noc_tx_o   = 1'b0;
      noc_data_o = '0;
      tx_ready_o = 1'b0;
      tx_busy_o  = 1'b1;
      w_tx_done  = 1'b0;
      w_tx_xfer  = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            tx_busy_o = 1'b0;
            if (tx_req_i) w_tx_next = TX_HDR;
         end
         TX_HDR: begin
            noc_tx_o   = 1'b1;
            noc_data_o = {{(FLIT_SIZE-16){1'b0}}, r_tx_target};
            if (noc_credit_i) w_tx_next = TX_SIZE;
         end
         TX_SIZE: begin
            noc_tx_o   = 1'b1;
            noc_data_o = r_tx_size;
            if (noc_credit_i) begin
               if (r_tx_size == '0) begin
                  w_tx_done = 1'b1;
                  w_tx_next = TX_IDLE;
               end else begin
                  w_tx_next = TX_PAYLOAD;
               end
            end
         end
         TX_PAYLOAD: begin
            noc_tx_o   = tx_valid_i;
            noc_data_o = tx_data_i;
            tx_ready_o = noc_credit_i;
            w_tx_xfer  = tx_valid_i && noc_credit_i;
            if (w_tx_xfer && r_tx_rem == FLIT_SIZE'(1)) begin
               w_tx_done = 1'b1;
               w_tx_next = TX_IDLE;
            end
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   // Target/size are only latched from idle so requests during a packet are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tx_state   <= TX_IDLE;
         r_tx_target  <= '0;
         r_tx_size    <= '0;
         r_tx_rem     <= '0;
         tx_pkt_cnt_o <= '0;
      end else begin
         r_tx_state <= w_tx_next;
         if (r_tx_state == TX_IDLE && tx_req_i) begin
            r_tx_target <= tx_target_i;
            r_tx_size   <= tx_size_i;
         end
         if (r_tx_state == TX_SIZE && noc_credit_i) r_tx_rem <= r_tx_size;
         else if (w_tx_xfer) r_tx_rem <= r_tx_rem - FLIT_SIZE'(1);
         if (w_tx_done) tx_pkt_cnt_o <= tx_pkt_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hermes_periph_bridge.sv
// tb/tb_hermes_periph_bridge.sv - self-checking bench for hermes_periph_bridge
// Cycle table for RX framing/gating, plus sequences for full FIFO, TX stalls and reset.
module tb_hermes_periph_bridge;

   logic        clk_i, rst_ni, release_i;
   logic        noc_rx_i, noc_credit_o, noc_tx_o, noc_credit_i;
   logic [31:0] noc_data_i, noc_data_o;
   logic        rx_valid_o, rx_ready_i, rx_sop_o, rx_eop_o;
   logic [31:0] rx_data_o;
   logic        tx_req_i, tx_busy_o, tx_valid_i, tx_ready_o;
   logic [15:0] tx_target_i;
   logic [31:0] tx_size_i, tx_data_i;
   logic [15:0] rx_pkt_cnt_o, tx_pkt_cnt_o;

   int n_pass  = 0;
   int n_total = 0;

   hermes_periph_bridge #(.FLIT_SIZE(32), .BUFFER_SIZE(8), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .release_i(release_i),
      .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o), .noc_data_i(noc_data_i),
      .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
      .rx_sop_o(rx_sop_o), .rx_eop_o(rx_eop_o),
      .tx_req_i(tx_req_i), .tx_target_i(tx_target_i), .tx_size_i(tx_size_i),
      .tx_busy_o(tx_busy_o), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .tx_data_i(tx_data_i), .rx_pkt_cnt_o(rx_pkt_cnt_o), .tx_pkt_cnt_o(tx_pkt_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [102:0] w_outs;
   assign w_outs = {noc_credit_o, noc_tx_o, noc_data_o, rx_valid_o, rx_data_o, rx_sop_o,
                    rx_eop_o, tx_busy_o, tx_ready_o, rx_pkt_cnt_o, tx_pkt_cnt_o};

   // in_f = {release, noc_rx, rx_ready}; e_f = {credit, valid, sop, eop}
   typedef struct {
      logic [2:0]  in_f;
      logic [31:0] data;
      logic [3:0]  e_f;
      logic [31:0] e_data;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic rx_pkt(input int n, input logic [31:0] base, input bit fill_first);
      logic [31:0] fl[$];
      int idx, got, cyc;
      bit c, v, s, e;
      logic [31:0] d;
      fl.push_back(32'h0000_0101);
      fl.push_back(32'(n));
      for (int i = 0; i < n; i++) fl.push_back(base + 32'(i));
      idx = 0; got = 0; cyc = 0; c = 1'b1;
      if (fill_first) begin
         while (c && cyc < 60) begin
            @(negedge clk_i);
            rx_ready_i = 1'b0;
            noc_rx_i   = (idx < fl.size());
            noc_data_i = noc_rx_i ? fl[idx] : 32'h0;
            #1 c = noc_credit_o;
            @(posedge clk_i);
            if (c && noc_rx_i) idx++;
            cyc++;
         end
         chk("full_credit_low", 1'(c), 1'b0);
         chk("full_flits_taken", idx, 10);
      end
      cyc = 0;
      while (got < n && cyc < 300) begin
         @(negedge clk_i);
         rx_ready_i = 1'b1;
         noc_rx_i   = (idx < fl.size());
         noc_data_i = noc_rx_i ? fl[idx] : 32'h0;
         #1;
         c = noc_credit_o; v = rx_valid_o; d = rx_data_o; s = rx_sop_o; e = rx_eop_o;
         if (v) chk($sformatf("rx_flit%0d", got), {d, s, e},
                    {base + 32'(got), 1'(got == 0), 1'(got == n - 1)});
         @(posedge clk_i);
         if (c && noc_rx_i) idx++;
         if (v) got++;
         cyc++;
      end
      chk("rx_all_flits", got, n);
      @(negedge clk_i);
      noc_rx_i = 1'b0; rx_ready_i = 1'b0;
   endtask

   task automatic tx_pkt(input logic [15:0] tgt, input int n, input logic [31:0] base,
                         input bit toggle, input bit poke_req);
      logic [31:0] exp[$];
      logic [31:0] got[$];
      logic [31:0] pd;
      int pidx, cyc, bad_hold;
      bit pstall, pt, busy, t, cr, rd;
      logic [31:0] d;
      exp.push_back({16'h0, tgt});
      exp.push_back(32'(n));
      for (int i = 0; i < n; i++) exp.push_back(base * 32'(i + 1));
      pidx = 0; cyc = 0; bad_hold = 0; pstall = 1'b0; pt = 1'b0; pd = 32'h0; busy = 1'b1;
      @(negedge clk_i);
      tx_req_i = 1'b1; tx_target_i = tgt; tx_size_i = 32'(n);
      noc_credit_i = 1'b0; tx_valid_i = 1'b0;
      @(posedge clk_i);
      while (busy && cyc < 100) begin
         @(negedge clk_i);
         tx_req_i = poke_req && cyc < 3;
         tx_target_i = 16'hFFFF; tx_size_i = 32'd7;
         noc_credit_i = toggle ? ((cyc % 2) == 1) : 1'b1;
         tx_valid_i = (pidx < n);
         tx_data_i  = base * 32'(pidx + 1);
         #1;
         busy = tx_busy_o; t = noc_tx_o; d = noc_data_o; cr = noc_credit_i; rd = tx_ready_o;
         if (busy) begin
            if (pstall && got.size() < 2 && (t != pt || d != pd)) bad_hold++;
            pstall = t && !cr; pt = t; pd = d;
            if (t && cr) got.push_back(d);
            if (rd && tx_valid_i) pidx++;
            @(posedge clk_i);
            cyc++;
         end
      end
      chk("tx_finished", 1'(busy), 1'b0);
      chk("tx_flit_count", got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("tx_flit%0d", i), got[i], exp[i]);
      chk("tx_hold_stable", bad_hold, 0);
      tx_req_i = 1'b0; tx_valid_i = 1'b0; noc_credit_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; release_i = 1'b0; noc_rx_i = 1'b0; noc_data_i = '0;
      noc_credit_i = 1'b0; rx_ready_i = 1'b0; tx_req_i = 1'b0; tx_target_i = '0;
      tx_size_i = '0; tx_valid_i = 1'b0; tx_data_i = '0;

      vecs[0]  = '{3'b111, 32'h101, 4'b1000, 32'h0, 16'd0};
      vecs[1]  = '{3'b111, 32'h3,   4'b1000, 32'h0, 16'd0};
      vecs[2]  = '{3'b111, 32'hA,   4'b1000, 32'h0, 16'd0};
      vecs[3]  = '{3'b111, 32'hB,   4'b1110, 32'hA, 16'd0};
      vecs[4]  = '{3'b111, 32'hC,   4'b1100, 32'hB, 16'd0};
      vecs[5]  = '{3'b101, 32'h0,   4'b1101, 32'hC, 16'd0};
      vecs[6]  = '{3'b101, 32'h0,   4'b1000, 32'h0, 16'd1};
      vecs[7]  = '{3'b111, 32'h101, 4'b1000, 32'h0, 16'd1};
      vecs[8]  = '{3'b111, 32'h0,   4'b1000, 32'h0, 16'd1};
      vecs[9]  = '{3'b101, 32'h0,   4'b1000, 32'h0, 16'd1};
      vecs[10] = '{3'b101, 32'h0,   4'b1000, 32'h0, 16'd2};
      vecs[11] = '{3'b010, 32'h101, 4'b0000, 32'h0, 16'd2};
      vecs[12] = '{3'b111, 32'h101, 4'b1000, 32'h0, 16'd2};
      vecs[13] = '{3'b111, 32'h1,   4'b1000, 32'h0, 16'd2};
      vecs[14] = '{3'b111, 32'hD,   4'b1000, 32'h0, 16'd2};
      vecs[15] = '{3'b101, 32'h0,   4'b1111, 32'hD, 16'd2};
      vecs[16] = '{3'b101, 32'h0,   4'b1000, 32'h0, 16'd3};

      repeat (2) @(negedge clk_i);
      #1 chk("reset_state", w_outs, 128'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk_i);
         {release_i, noc_rx_i, rx_ready_i} = vecs[i].in_f;
         noc_data_i = vecs[i].data;
         #1 chk($sformatf("vec%0d", i),
                {noc_credit_o, rx_valid_o, rx_sop_o, rx_eop_o, rx_data_o, rx_pkt_cnt_o},
                {vecs[i].e_f, vecs[i].e_data, vecs[i].e_cnt});
         @(posedge clk_i);
      end
      @(negedge clk_i);
      noc_rx_i = 1'b0; release_i = 1'b1;

      rx_pkt(20, 32'h100, 1'b1);
      #1 chk("rx_cnt_after_full", rx_pkt_cnt_o, 16'd4);

      tx_pkt(16'h0203, 2, 32'h11, 1'b1, 1'b1);
      #1 chk("tx_cnt_stall", tx_pkt_cnt_o, 16'd1);
      tx_pkt(16'h0405, 0, 32'h0, 1'b0, 1'b0);
      #1 chk("tx_cnt_zero", tx_pkt_cnt_o, 16'd2);

      // RX and TX mid-payload together, then asynchronous reset.
      @(negedge clk_i);
      rx_ready_i = 1'b1; noc_credit_i = 1'b1; tx_valid_i = 1'b1; tx_data_i = 32'h55;
      tx_req_i = 1'b1; tx_target_i = 16'h0304; tx_size_i = 32'd4;
      noc_rx_i = 1'b1; noc_data_i = 32'h101;
      @(posedge clk_i);
      @(negedge clk_i); tx_req_i = 1'b0; noc_data_i = 32'd5;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk_i);
         @(negedge clk_i); noc_data_i = 32'(i);
      end
      #1 chk("concurrent_active", {rx_valid_o, tx_busy_o}, 2'b11);
      #1;
      rst_ni = 1'b0; noc_rx_i = 1'b0; tx_valid_i = 1'b0; rx_ready_i = 1'b0;
      noc_credit_i = 1'b0; tx_data_i = '0; noc_data_i = '0;
      #1 chk("reset_mid_packet", w_outs, {1'b1, 102'h0});
      @(negedge clk_i);
      rst_ni = 1'b1;

      rx_pkt(3, 32'hA, 1'b0);
      #1 chk("rx_cnt_post_reset", rx_pkt_cnt_o, 16'd1);
      tx_pkt(16'h0203, 2, 32'h11, 1'b0, 1'b0);
      #1 chk("tx_cnt_post_reset", tx_pkt_cnt_o, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
